// File: rtl/serializer.sv
// 16-bit parallel-to-serial converter, MSB first, with a programmable bit
// count. A word is captured from idle, shifted out one bit per clock, and the
// block then returns to idle for at least one cycle before the next word.
//
// Request handshake: data_val_i qualifies data_i/data_mod_i on any rising
// edge. A request is taken only on an edge where busy_o=0 and the length is
// legal (data_mod_i=0 means 16, 3..15 literal, 1 and 2 are dropped). busy_o
// is the inverse of "ready". Requests seen while busy_o=1 are discarded and
// are not queued, so the requester must hold or re-present them.
module serializer (
  input  logic        clk_i,
  input  logic        arstn_i,
  input  logic [15:0] data_i,
  input  logic [3:0]  data_mod_i,
  input  logic        data_val_i,
  output logic        ser_data_o,
  output logic        ser_data_val_o,
  output logic        busy_o,
  output logic        dbg_state_o
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  logic [0:0]  state_q;
  logic [15:0] shift_q;   // remaining bits, next bit to send in [15]
  logic [4:0]  cnt_q;     // bits still to send after the one on ser_data_o
  logic        len_ok;
  logic [4:0]  first_cnt;

  // Decode the requested length: legal lengths and the count left after bit 0.
  always_comb begin
    len_ok    = (data_mod_i != 4'd1) && (data_mod_i != 4'd2);
    first_cnt = (data_mod_i == 4'd0) ? 5'd15 : ({1'b0, data_mod_i} - 5'd1);
  end

  // Two-state FSM driving all outputs from registers.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q        <= ST_IDLE;
      shift_q        <= 16'h0000;
      cnt_q          <= 5'd0;
      ser_data_o     <= 1'b0;
      ser_data_val_o <= 1'b0;
      busy_o         <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (data_val_i && len_ok) begin
            // Bit 15 goes out right away; the rest wait in the shifter.
            state_q        <= ST_SHIFT;
            shift_q        <= {data_i[14:0], 1'b0};
            cnt_q          <= first_cnt;
            ser_data_o     <= data_i[15];
            ser_data_val_o <= 1'b1;
            busy_o         <= 1'b1;
          end else begin
            ser_data_o     <= 1'b0;
            ser_data_val_o <= 1'b0;
            busy_o         <= 1'b0;
          end
        end
        default: begin
          if (cnt_q == 5'd0) begin
            // Last bit has been on the line for one cycle; go quiet.
            state_q        <= ST_IDLE;
            shift_q        <= 16'h0000;
            ser_data_o     <= 1'b0;
            ser_data_val_o <= 1'b0;
            busy_o         <= 1'b0;
          end else begin
            shift_q        <= {shift_q[14:0], 1'b0};
            cnt_q          <= cnt_q - 5'd1;
            ser_data_o     <= shift_q[15];
            ser_data_val_o <= 1'b1;
            busy_o         <= 1'b1;
          end
        end
      endcase
    end
  end

  // Expose the FSM state for observation.
  always_comb begin
    dbg_state_o = state_q[0];
  end

endmodule

// File: tb/tb_serializer.sv
// Testbench for serializer: directed scenarios followed by random traffic,
// all checked cycle by cycle against a bit-queue reference model.
module tb_serializer;

  logic        clk;
  logic        arstn;
  logic [15:0] data;
  logic [3:0]  data_mod;
  logic        data_val;
  logic        ser_data;
  logic        ser_data_val;
  logic        busy;
  logic        dbg_state;

  int checks   = 0;
  int failures = 0;

  // Reference model: queue of bits still to appear, plus expected outputs.
  logic [0:0]  exp_q[$];
  logic        exp_val;
  logic        exp_bit;

  // Collected valid bits, for whole-word checks.
  logic [15:0] got;
  int          got_n;

  serializer dut (
    .clk_i          (clk),
    .arstn_i        (arstn),
    .data_i         (data),
    .data_mod_i     (data_mod),
    .data_val_i     (data_val),
    .ser_data_o     (ser_data),
    .ser_data_val_o (ser_data_val),
    .busy_o         (busy),
    .dbg_state_o    (dbg_state)
  );

  // Clock generation.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_pop();
    if (exp_q.size() > 0) begin
      exp_val = 1'b1;
      exp_bit = exp_q.pop_front();
    end else begin
      exp_val = 1'b0;
      exp_bit = 1'b0;
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    exp_val = 1'b0;
    exp_bit = 1'b0;
  endtask

  // Advance the model by one rising edge using the inputs held across it.
  task automatic model_edge();
    int n;
    if (!arstn) begin
      model_clear();
    end else if (!exp_val) begin
      if (data_val && data_mod != 4'd1 && data_mod != 4'd2) begin
        n = (data_mod == 4'd0) ? 16 : int'(data_mod);
        for (int k = 0; k < n; k++) exp_q.push_back(data[15-k]);
      end
      model_pop();
    end else begin
      model_pop();
    end
  endtask

  task automatic check_outputs();
    chk("ser_data_val", {31'd0, ser_data_val}, {31'd0, exp_val});
    chk("ser_data", {31'd0, ser_data}, {31'd0, exp_bit});
    chk("busy", {31'd0, busy}, {31'd0, exp_val});
    if (ser_data_val === 1'b1) begin
      got = {got[14:0], ser_data};
      got_n++;
    end
  endtask

  // One clock: model follows the rising edge, outputs checked on the falling edge.
  task automatic cyc(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_outputs();
    end
  endtask

  task automatic clr_got();
    got   = 16'h0000;
    got_n = 0;
  endtask

  initial begin
    arstn    = 1'b0;
    data     = 16'h0000;
    data_mod = 4'd0;
    data_val = 1'b0;
    model_clear();
    clr_got();

    // Reset held: outputs idle, requests ignored.
    #2;
    chk("reset_val", {31'd0, ser_data_val}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_data", {31'd0, ser_data}, 32'd0);
    data_val = 1'b1;
    data     = 16'hFFFF;
    cyc(3);
    data_val = 1'b0;
    @(negedge clk);
    arstn = 1'b1;

    // Full word, presented on the first edge after reset release.
    clr_got();
    data = 16'hDAAC; data_mod = 4'd0; data_val = 1'b1;
    cyc(1);
    data_val = 1'b0; data = 16'h1234;
    cyc(15);
    chk("full_word_bits", {16'd0, got}, 32'h0000_DAAC);
    chk("full_word_len", got_n, 16);
    cyc(1);
    chk("full_word_end_busy", {31'd0, busy}, 32'd0);
    cyc(2);

    // Partial word of five ones.
    clr_got();
    data = 16'hFFFF; data_mod = 4'd5; data_val = 1'b1;
    cyc(1);
    data_val = 1'b0;
    cyc(8);
    chk("partial_len", got_n, 5);
    chk("partial_bits", {27'd0, got[4:0]}, 32'h1F);

    // Minimum length.
    clr_got();
    data = 16'hA000; data_mod = 4'd3; data_val = 1'b1;
    cyc(1);
    data_val = 1'b0;
    cyc(5);
    chk("min_len", got_n, 3);
    chk("min_bits", {29'd0, got[2:0]}, 32'h5);

    // Illegal lengths 1 and 2 are dropped.
    clr_got();
    data = 16'hFFFF; data_mod = 4'd1; data_val = 1'b1;
    cyc(3);
    data_mod = 4'd2;
    cyc(3);
    data_val = 1'b0;
    cyc(2);
    chk("illegal_len_bits", got_n, 0);

    // New request mid-transfer is ignored and not queued.
    clr_got();
    data = 16'hFFFF; data_mod = 4'd0; data_val = 1'b1;
    cyc(1);
    data_val = 1'b0;
    cyc(4);
    data = 16'h0000; data_mod = 4'd4; data_val = 1'b1;
    cyc(1);
    data_val = 1'b0;
    cyc(16);
    chk("ignore_busy_len", got_n, 16);
    chk("ignore_busy_bits", {16'd0, got}, 32'h0000_FFFF);

    // Back-to-back with the request held: 4 bits, 1 idle, repeating.
    clr_got();
    data = 16'h9000; data_mod = 4'd4; data_val = 1'b1;
    cyc(15);
    chk("b2b_bits", got_n, 12);
    chk("b2b_gap_idle", {31'd0, busy}, 32'd0);
    data_val = 1'b0;
    cyc(6);

    // Reset mid-transfer aborts immediately.
    clr_got();
    data = 16'hFFFF; data_mod = 4'd0; data_val = 1'b1;
    cyc(1);
    data_val = 1'b0;
    cyc(5);
    arstn = 1'b0;
    #1;
    model_clear();
    chk("abort_val", {31'd0, ser_data_val}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_data", {31'd0, ser_data}, 32'd0);
    cyc(2);
    @(negedge clk);
    arstn = 1'b1;
    cyc(20);
    chk("abort_no_more_bits", got_n, 6);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      data     = 16'($urandom);
      data_mod = 4'($urandom_range(0, 15));
      data_val = ($urandom_range(0, 2) == 0);
      cyc(1);
    end
    data_val = 1'b0;
    cyc(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serializer.md
SERIALIZER -- requirements
Module: serializer

Interface
REQ-001 Parameter: none; data width fixed at 16 bits, length field fixed at 4 bits.
REQ-002 clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 arstn_i  input  1  reset, asynchronous assert, active-low; deassertion sampled on clk_i.
REQ-004 data_i  input  16  parallel word; bit 15 is transmitted first.
REQ-005 data_mod_i  input  4  number of valid bits to send; 0 means 16.
REQ-006 data_val_i  input  1  request strobe qualifying data_i/data_mod_i.
REQ-007 ser_data_o  output  1  serial data bit, MSB first.
REQ-008 ser_data_val_o  output  1  high on every cycle ser_data_o carries a valid bit.
REQ-009 busy_o  output  1  high while a word is being shifted out; new requests ignored.

Function
REQ-010 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-011 Idle state: busy_o=0, ser_data_val_o=0, ser_data_o=0.
REQ-012 Acceptance: on a rising edge where busy_o=0 and data_val_i=1 with a valid length, the block SHALL capture data_i and data_mod_i.
REQ-013 Valid lengths: data_mod_i=0 -> N=16; data_mod_i in 3..15 -> N=data_mod_i.
REQ-014 data_mod_i=1 or 2 SHALL be rejected: request dropped, block stays idle, no output activity.
REQ-015 Latency: first bit (data_i[15]) SHALL appear on ser_data_o with ser_data_val_o=1 in the cycle immediately after the acceptance edge.
REQ-016 Bit order: cycle k (k=0..N-1) after start SHALL present captured data[15-k]; bits data[15-N:0] are never sent.
REQ-017 ser_data_val_o SHALL stay high for exactly N consecutive cycles, with no gaps.
REQ-018 busy_o SHALL equal ser_data_val_o: high for exactly the same N cycles.
REQ-019 After the last bit, busy_o, ser_data_val_o and ser_data_o SHALL drop to 0 on the next edge unless a new word starts.
REQ-020 data_val_i, data_i and data_mod_i SHALL be ignored while busy_o=1; changing them mid-transfer does not affect the word in flight.
REQ-021 Back-to-back: a request held or presented on the first cycle busy_o=0 SHALL be accepted, and its first bit appears the following cycle. Minimum gap between words is one idle cycle.
REQ-022 State machine: IDLE -> SHIFT on valid acceptance. SHIFT -> IDLE after the N-th bit. Remaining-bit counter SHALL be wide enough for 16.

Reset
REQ-023 While arstn_i=0: ser_data_o=0, ser_data_val_o=0, busy_o=0, counter cleared, state=IDLE, independent of clk_i.
REQ-024 Reset asserted mid-transfer SHALL abort the word immediately; no remaining bits are sent after release.
REQ-025 The first request SHALL be accepted on the first rising edge after reset release with arstn_i=1.

Verification
REQ-026 Full word: data_i=16'hDAAC, data_mod_i=0, one-cycle data_val_i -> ser_data_val_o high 16 cycles, bits 1,1,0,1,1,0,1,0,1,0,1,0,1,1,0,0, busy_o low on the 17th cycle.
REQ-027 Partial: data_i=16'hFFFF, data_mod_i=5 -> five 1s with ser_data_val_o=1, then ser_data_val_o=0 and busy_o=0 on the following cycle and after.
REQ-028 Minimum/invalid lengths: data_mod_i=3 with data_i=16'hA000 -> bits 1,0,1. data_mod_i=1 or 2 -> busy_o and ser_data_val_o stay 0.
REQ-029 Ignore while busy: during a 16-bit transfer of 16'hFFFF, pulse data_val_i with data_i=16'h0000 -> output stays all 1s for 16 cycles, and no second word follows.
REQ-030 Back-to-back: hold data_val_i=1 continuously with data_mod_i=4 -> 4 valid bits, 1 idle cycle, 4 valid bits, repeating.
REQ-031 Reset mid-transfer: assert arstn_i=0 on bit 6 of a 16-bit word -> all outputs 0 at once (asynchronous), no further bits after release until a new request.
